// File: rtl/data_addr_trans_stage.sv
// Load/store address-translation stage: MMU request, exception classification, output FIFO toward dcache.
// Optional alignment check (ALE, ecode 0x09) enabled by defining DATA_ALIGN_CHECK_EN.
module data_addr_trans_stage #(
    parameter int TAG_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [1:0]       csr_plv_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_vaddr_i,
    input  logic             in_store_i,
    input  logic [1:0]       in_size_i,
    input  logic             in_cacop_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             mmu_req_valid_o,
    output logic [31:0]      mmu_req_vaddr_o,
    output logic             mmu_req_cacop_o,
    input  logic             mmu_miss_i,
    input  logic             mmu_tlb_used_i,
    input  logic [31:0]      mmu_paddr_i,
    input  logic             mmu_uncache_i,
    input  logic             mmu_tlb_v_i,
    input  logic             mmu_tlb_d_i,
    input  logic [1:0]       mmu_tlb_plv_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_paddr_o,
    output logic [31:0]      out_vaddr_o,
    output logic             out_store_o,
    output logic             out_uncache_o,
    output logic             out_excp_o,
    output logic [5:0]       out_ecode_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [31:0]      paddr;
        logic [31:0]      vaddr;
        logic             store;
        logic             uncache;
        logic             excp;
        logic [5:0]       ecode;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // TLB-path exception ranking; 0 means no exception.
    function automatic logic [5:0] tlb_ecode(input logic       tlb_used,
                                             input logic       miss,
                                             input logic       pg_v,
                                             input logic       pg_d,
                                             input logic       store,
                                             input logic [1:0] csr_plv,
                                             input logic [1:0] pg_plv);
        logic [5:0] code;
        code = 6'h00;
        if (tlb_used) begin
            if (miss)                 code = 6'h3F;
            else if (!pg_v)           code = store ? 6'h02 : 6'h01;
            else if (csr_plv > pg_plv) code = 6'h07;
            else if (store && !pg_d)  code = 6'h04;
        end
        return code;
    endfunction

`ifdef DATA_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] va_lo);
        return (size == 2'd1 && va_lo[0]) || (size == 2'd2 && va_lo != 2'b00);
    endfunction
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic             vld_p1;
    logic [31:0]      vaddr_p1;
    logic             store_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wptr, rptr;
    entry_t           mem [DEPTH];
    entry_t           push_ent;
    entry_t           head;
    logic             accept_p0, push, pop;

`ifdef DATA_ALIGN_CHECK_EN
    logic [1:0]       size_p1;
`else
    logic             unused_size;
    assign unused_size = ^in_size_i;
`endif

    // ---- p0: request issue toward the MMU ----
    // Counting the S1 occupant reserves its FIFO slot before the MMU answers.
    assign in_ready_o      = ((count + CNT_W'(vld_p1)) < CNT_W'(DEPTH)) && !flush_i;
    assign accept_p0       = in_valid_i && in_ready_o;
    assign mmu_req_valid_o = accept_p0;
    assign mmu_req_vaddr_o = in_vaddr_i;
    assign mmu_req_cacop_o = in_cacop_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= accept_p0;
    end

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            vaddr_p1 <= in_vaddr_i;
            store_p1 <= in_store_i;
            tag_p1   <= in_tag_i;
`ifdef DATA_ALIGN_CHECK_EN
            size_p1  <= in_size_i;
`endif
        end
    end

    // ---- p1: MMU response capture and classification ----
    always_comb begin
        push_ent.ecode = tlb_ecode(mmu_tlb_used_i, mmu_miss_i, mmu_tlb_v_i, mmu_tlb_d_i,
                                   store_p1, csr_plv_i, mmu_tlb_plv_i);
`ifdef DATA_ALIGN_CHECK_EN
        if (misaligned(size_p1, vaddr_p1[1:0])) push_ent.ecode = 6'h09;
`endif
        push_ent.excp    = (push_ent.ecode != 6'h00);
        push_ent.paddr   = push_ent.excp ? vaddr_p1 : mmu_paddr_i;
        push_ent.vaddr   = vaddr_p1;
        push_ent.store   = store_p1;
        push_ent.uncache = mmu_uncache_i;
        push_ent.tag     = tag_p1;
    end

    assign push = vld_p1 && !flush_i;
    assign pop  = (count != '0) && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (flush_i) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_ent;
    end

    // ---- p2: FIFO head toward the dcache ----
    // Fields are forced to zero when empty so stale entries never appear after reset or flush.
    assign head          = mem[rptr];
    assign out_valid_o   = (count != '0);
    assign out_paddr_o   = out_valid_o ? head.paddr   : '0;
    assign out_vaddr_o   = out_valid_o ? head.vaddr   : '0;
    assign out_store_o   = out_valid_o & head.store;
    assign out_uncache_o = out_valid_o & head.uncache;
    assign out_excp_o    = out_valid_o & head.excp;
    assign out_ecode_o   = out_valid_o ? head.ecode   : '0;
    assign out_tag_o     = out_valid_o ? head.tag     : '0;

endmodule
